// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo: PS/2 scan-code decoder feeding a key-event FIFO; optional typematic repeat filter under KEY_REPEAT_FILTER_EN
module ps2_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout
);
  typedef enum logic [1:0] {S_IDLE, S_DPS, S_LOAD} rx_state_t;
  rx_state_t   state_q, state_d;
  logic [7:0]  filt_q, filt_d;
  logic        fclk_q, fclk_d;
  logic [3:0]  n_q, n_d;
  logic [9:0]  b_q, b_d;
  logic        fall;
  // debounce the PS/2 clock and shift in 11 bits on its falling edges
  always_comb begin
    filt_d = {ps2c, filt_q[7:1]};
    fclk_d = (&filt_q) ? 1'b1 : (~|filt_q) ? 1'b0 : fclk_q;
    fall = fclk_q & ~fclk_d;
    state_d = state_q;
    n_d = n_q;
    b_d = b_q;
    case (state_q)
      S_IDLE: if (fall && rx_en) begin
        b_d = {ps2d, b_q[9:1]};
        n_d = 4'd9;
        state_d = S_DPS;
      end
      S_DPS: if (fall) begin
        b_d = {ps2d, b_q[9:1]};
        n_d = n_q - 4'd1;
        state_d = (n_q == 4'd0) ? S_LOAD : S_DPS;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // receiver state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      filt_q <= 8'hff;
      fclk_q <= 1'b1;
      n_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      filt_q <= filt_d;
      fclk_q <= fclk_d;
      n_q <= n_d;
      b_q <= b_d;
    end
  end
  // a frame is only reported with a good stop bit and odd parity
  assign rx_done_tick = (state_q == S_LOAD) & b_q[9] & (^b_q[8:0]);
  assign dout = b_q[7:0];
endmodule

module ps2_key_event_fifo #(
  parameter int FIFO_W      = 2,
  parameter bit REPORT_MAKE = 1'b1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ps2d,
  input  logic            ps2c,
  input  logic            rd_ack,
  input  logic            clr_ovf,
  output logic [7:0]      key_code,
  output logic            key_ext,
  output logic            key_brk,
  output logic            key_valid,
  output logic [FIFO_W:0] fifo_count,
  output logic            overflow
);
  localparam int DEPTH = 2**FIFO_W;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;
  state_t          state_q, state_d;
  logic            ext_q, ext_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rx_done_tick;
  logic [7:0]      dout;
  logic            is_err, ev, ev_ext, ev_brk, drop, push, pop, full, wr_en;
  logic [FIFO_W:0] wr_q, wr_d, rd_q, rd_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      mem_q [DEPTH];

  ps2_rx u_rx (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(1'b1),
    .rx_done_tick(rx_done_tick), .dout(dout)
  );

  assign is_err = (dout == 8'h00) || (dout == 8'hff);
  // prefix decoder: collapses E0/F0 sequences into one event, aborting stale prefixes
  always_comb begin
    state_d = state_q;
    ext_d = ext_q;
    tmo_d = '0;
    ev = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (dout == 8'he0) state_d = EXT;
          else if (dout == 8'hf0) begin
            state_d = BRK;
            ext_d = 1'b0;
          end else ev = ~is_err;
        end
        EXT: begin
          if (dout == 8'hf0) begin
            state_d = BRK;
            ext_d = 1'b1;
          end else if (dout != 8'he0) begin
            state_d = IDLE;
            ev = ~is_err;
            ev_ext = 1'b1;
          end
        end
        BRK: begin
          if (dout != 8'hf0 && dout != 8'he0) begin
            state_d = IDLE;
            ext_d = 1'b0;
            ev = ~is_err;
            ev_ext = ext_q;
            ev_brk = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        ext_d = 1'b0;
      end else tmo_d = tmo_q + 1'b1;
    end
  end
  // decoder state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ext_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      ext_q <= ext_d;
      tmo_q <= tmo_d;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [9:0] held_q, held_d;
  assign drop = ev & ~ev_brk & held_q[9] & (held_q[8:0] == {ev_ext, dout});
  // remember the last key pressed; its release disarms the repeat filter
  always_comb held_d = !ev ? held_q :
                       !ev_brk ? (REPORT_MAKE ? {1'b1, ev_ext, dout} : held_q) :
                       (held_q[8:0] == {ev_ext, dout}) ? {1'b0, held_q[8:0]} : held_q;
  // held-key register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) held_q <= '0;
    else held_q <= held_d;
  end
`else
  assign drop = 1'b0;
`endif

  assign push = ev & ~drop & (ev_brk | REPORT_MAKE);
  assign fifo_count = wr_q - rd_q;
  assign key_valid = fifo_count != '0;
  assign full = fifo_count == (FIFO_W+1)'(DEPTH);
  assign pop = rd_ack & key_valid;
  assign wr_en = push & (~full | pop);
  // pointer and sticky-overflow next state; a drop beats a same-cycle clear
  always_comb begin
    wr_d = wr_q + (FIFO_W+1)'(wr_en);
    rd_d = rd_q + (FIFO_W+1)'(pop);
    ovf_d = (push & full & ~pop) | (ovf_q & ~clr_ovf);
  end
  // FIFO pointers and overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end
  // event storage; stale contents are masked at the outputs while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[FIFO_W-1:0]] <= {ev_ext, ev_brk, dout};
  end
  assign {key_ext, key_brk, key_code} = key_valid ? mem_q[rd_q[FIFO_W-1:0]] : 10'd0;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb_ps2_key_event_fifo: directed bench for the PS/2 key event FIFO (make+break and break-only instances)
module tb_ps2_key_event_fifo;
  localparam int H = 12;
  logic clk = 1'b0, reset = 1'b1, ps2d = 1'b1, ps2c = 1'b1;
  logic rd_ack_a = 1'b0, rd_ack_b = 1'b0, clr_ovf = 1'b0;
  logic [7:0] code_a, code_b;
  logic ext_a, brk_a, valid_a, ovf_a, ext_b, brk_b, valid_b, ovf_b;
  logic [2:0] cnt_a, cnt_b;
  logic [9:0] head_a, head_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ps2_key_event_fifo #(.FIFO_W(2), .REPORT_MAKE(1'b1), .TIMEOUT_CYC(600)) u_a (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_ack(rd_ack_a), .clr_ovf(clr_ovf),
    .key_code(code_a), .key_ext(ext_a), .key_brk(brk_a), .key_valid(valid_a),
    .fifo_count(cnt_a), .overflow(ovf_a)
  );
  ps2_key_event_fifo #(.FIFO_W(2), .REPORT_MAKE(1'b0), .TIMEOUT_CYC(600)) u_b (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_ack(rd_ack_b), .clr_ovf(1'b0),
    .key_code(code_b), .key_ext(ext_b), .key_brk(brk_b), .key_valid(valid_b),
    .fifo_count(cnt_b), .overflow(ovf_b)
  );

  assign head_a = {ext_a, brk_a, code_a};
  assign head_b = {ext_b, brk_b, code_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = f[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
    end
    repeat (2*H) @(negedge clk);
  endtask

  task automatic pop_a;
    rd_ack_a = 1'b1;
    @(negedge clk);
    rd_ack_a = 1'b0;
  endtask

  task automatic pop_b;
    rd_ack_b = 1'b1;
    @(negedge clk);
    rd_ack_b = 1'b0;
  endtask

  task automatic send_ack(input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    fork
      send(d);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          if (u_a.rx_done_tick) begin
            seen = 1'b1;
            rd_ack_a = 1'b1;
            @(negedge clk);
            rd_ack_a = 1'b0;
          end
        end
      end
    join
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_head", 32'(head_a), 32'h000);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    send(8'h1c); send(8'hf0); send(8'h1c);
    chk("mb_count", 32'(cnt_a), 32'd2);
    chk("mb_head0", 32'(head_a), 32'h01c);
    chk("b_only_count", 32'(cnt_b), 32'd1);
    chk("b_only_head", 32'(head_b), 32'h11c);
    pop_a;
    chk("mb_head1", 32'(head_a), 32'h11c);
    pop_a;
    chk("mb_empty", 32'(valid_a), 32'd0);
    pop_a;
    chk("ack_empty_count", 32'(cnt_a), 32'd0);
    pop_b;
    chk("b_drained", 32'(cnt_b), 32'd0);

    send(8'he0); send(8'h75); send(8'he0); send(8'hf0); send(8'h75);
    chk("ext_count", 32'(cnt_a), 32'd2);
    chk("ext_make", 32'(head_a), 32'h275);
    pop_a;
    chk("ext_brk", 32'(head_a), 32'h375);
    pop_a;
    chk("b_ext_brk", 32'(head_b), 32'h375);
    pop_b;

    send(8'h15); send(8'h1d); send(8'h24); send(8'h2d); send(8'h2c);
    chk("full_count", 32'(cnt_a), 32'd4);
    chk("full_ovf", 32'(ovf_a), 32'd1);
    chk("full_head", 32'(head_a), 32'h015);
    send_ack(8'h1b);
    chk("pushpop_count", 32'(cnt_a), 32'd4);
    chk("pushpop_head", 32'(head_a), 32'h01d);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf_a), 32'd0);
    pop_a;
    chk("wrap_h1", 32'(head_a), 32'h024);
    pop_a;
    chk("wrap_h2", 32'(head_a), 32'h02d);
    pop_a;
    chk("wrap_h3", 32'(head_a), 32'h01b);
    pop_a;
    chk("wrap_empty", 32'(cnt_a), 32'd0);

    send(8'hf0);
    repeat (800) @(negedge clk);
    send(8'h1c);
    chk("tmo_count", 32'(cnt_a), 32'd1);
    chk("tmo_head", 32'(head_a), 32'h01c);
    chk("tmo_b_none", 32'(cnt_b), 32'd0);
    pop_a;

    send(8'h1c); send(8'hf0);
    chk("pre_rst_count", 32'(cnt_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(cnt_a), 32'd0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_head", 32'(head_a), 32'h000);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send_ack(8'h1c);
    chk("empty_pushpop_count", 32'(cnt_a), 32'd1);
    chk("post_rst_head", 32'(head_a), 32'h01c);
    pop_a;

    send(8'h1c); send(8'h1c); send(8'h1c); send(8'hf0); send(8'h1c);
`ifdef KEY_REPEAT_FILTER_EN
    chk("rep_count", 32'(cnt_a), 32'd2);
    chk("rep_head0", 32'(head_a), 32'h01c);
    pop_a;
    chk("rep_head1", 32'(head_a), 32'h11c);
`else
    chk("rep_count", 32'(cnt_a), 32'd4);
    chk("rep_head0", 32'(head_a), 32'h01c);
    pop_a;
    pop_a;
    pop_a;
    chk("rep_head3", 32'(head_a), 32'h11c);
`endif
    chk("rep_ovf", 32'(ovf_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Next-generation PS/2 keyboard front end. Instantiates the existing ps2_rx receiver.
- Decodes make, break (F0) and extended (E0) scan-code sequences into single key events.
- Buffers events in a parametrised FIFO, with a valid/ack handshake to the consuming FSM.
- Replaces the single-slot break-only capture: no lost keys while the consumer is busy, and full make/break/extended reporting.

Parameters:
FIFO_W, 2, log2 of FIFO depth (depth = 2**FIFO_W entries of 10 bits)
REPORT_MAKE, 1, 1 = enqueue make and break events; 0 = enqueue break events only
TIMEOUT_CYC, 2000000, idle clk cycles inside a prefix sequence before the decoder aborts to IDLE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2d  in  1  PS/2 data line (to ps2_rx)
ps2c  in  1  PS/2 clock line (to ps2_rx)
rd_ack  in  1  consumer pops head entry (1-cycle pulse)
clr_ovf  in  1  clears overflow flag
key_code  out  8  scan code of head entry
key_ext  out  1  head entry had E0 prefix
key_brk  out  1  head entry is a release (F0)
key_valid  out  1  FIFO non-empty
fifo_count  out  FIFO_W+1  number of stored entries
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset (async, any time, including mid-sequence):
  - FSM returns to IDLE; ext flag cleared; timeout counter = 0.
  - FIFO pointers = 0, so fifo_count=0 and key_valid=0.
  - overflow=0; key_code/key_ext/key_brk = 0.
  - Repeat-filter register cleared.
- ps2_rx is instantiated with rx_en tied to 1. A byte is consumed on each rx_done_tick, with value dout.
- Decoder FSM states: IDLE, EXT, BRK. The ext flag is registered.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK with ext=0.
    - 00 or FF (keyboard error) -> discard, stay IDLE.
    - Any other byte -> make event {ext=0,brk=0,code}, stay IDLE.
  - EXT:
    - F0 -> BRK with ext=1.
    - E0 -> stay EXT.
    - 00/FF -> IDLE, discard.
    - Other byte -> make event {1,0,code}, then IDLE.
  - BRK:
    - F0 or E0 -> stay BRK, ext unchanged.
    - 00/FF -> IDLE, discard.
    - Other byte -> break event {ext,1,code}, then IDLE; ext cleared.
- Timeout:
  - The counter runs only in EXT or BRK and resets on every rx_done_tick.
  - At TIMEOUT_CYC it forces IDLE and clears ext. No event is generated.
- Event generation:
  - The push strobe is asserted in the same cycle as the terminating rx_done_tick.
  - The entry is visible at the outputs (key_valid=1) on the next cycle.
  - With REPORT_MAKE=0, make events are suppressed; the FSM still tracks the sequence.
- FIFO:
  - Outputs show the head entry directly from storage; no extra latency.
  - Pop when rd_ack=1 and key_valid=1. rd_ack while empty is ignored.
  - Push and pop in the same cycle, with the FIFO full or non-empty: both occur and the count is unchanged.
  - Push and pop in the same cycle with the FIFO empty: the new entry is written, the pop is ignored, and the count goes to 1.
  - Push when full with no pop: the new event is dropped, the FIFO is unchanged, and overflow is set to 1.
  - Pointers wrap modulo depth. fifo_count ranges 0..2**FIFO_W.
- overflow:
  - Cleared by clr_ovf.
  - If a set and a clear fall in the same cycle, the set wins.

Optional Feature:
- Macro KEY_REPEAT_FILTER_EN.
- Defined:
  - A held-key register {valid,ext,code} is loaded on each enqueued make event.
  - A make event matching the held key while valid is dropped (typematic repeat suppression) and does not set overflow.
  - A break matching the held key clears valid.
  - A make of a different key replaces the held key.
- Undefined: every make event is enqueued, including typematic repeats. No held-key register is built.

Test Plan:
- REPORT_MAKE=1; send 1C, F0, 1C -> two entries: {ext0,brk0,1C} then {ext0,brk1,1C}; fifo_count=2; popping both with rd_ack gives key_valid=0.
- Send E0 75, then E0 F0 75 -> entries {1,0,75} and {1,1,75}.
- REPORT_MAKE=0; send 1C F0 1C -> single entry {0,1,1C}.
- FIFO_W=2; five make events (15,1D,24,2D,2C) with no rd_ack -> fifo_count=4, overflow=1, head=15. Assert rd_ack and push a sixth event in the same cycle -> count stays 4 and head=1D. Pulse clr_ovf -> overflow=0.
- TIMEOUT_CYC=100; send F0, idle 150 cycles, send 1C -> entry {0,0,1C}, not a break.
- Send F0, assert reset, release, send 1C -> FIFO empty right after reset; then single make entry {0,0,1C}.
- With KEY_REPEAT_FILTER_EN: send 1C 1C 1C F0 1C -> entries {0,0,1C}, {0,1,1C} only.
